// File: rtl/ps2_key_rx_if.sv
// ============================================================================
// Module  : ps2_key_rx_if
// Brief   : Key-event valid/ready port between the PS/2 receiver and its consumer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface ps2_key_rx_if;
  logic [7:0] key_code;
  logic       key_brk;
  logic       key_ext;
  logic       key_valid;
  logic       key_ready;

  modport master (
    output key_code, key_brk, key_ext, key_valid,
    input  key_ready
  );

  modport slave (
    input  key_code, key_brk, key_ext, key_valid,
    output key_ready
  );
endinterface

`default_nettype wire

// File: rtl/ps2_key_rx.sv
// ============================================================================
// Module  : ps2_key_rx
// Brief   : PS/2 keyboard receiver with glitch filter, E0/F0 folding and event FIFO.
//           Define PS2_PARITY_CHK_EN to enforce odd parity on received frames.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_key_rx #(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8
) (
  input  wire logic      clk,
  input  wire logic      rst,
  input  wire logic      ps2_clk,
  input  wire logic      ps2_data,
  ps2_key_rx_if.master   key,
  output logic           ovf,
  output logic           frame_err
);

  localparam int c_FILT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int c_TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int c_AW     = $clog2(FIFO_DEPTH);
  localparam int c_CW     = c_AW + 1;
  localparam logic [c_FILT_W-1:0] c_FILT_MAX = c_FILT_W'(FILT_LEN - 1);
  localparam logic [c_TO_W-1:0]   c_TO_MAX   = c_TO_W'(TIMEOUT_CYC - 1);
  localparam logic [c_CW-1:0]     c_FULL     = c_CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // ---------------------------------------------------------------- input path
  logic [1:0]          r_clk_s;
  logic [1:0]          r_dat_s;
  logic                r_filt_clk;
  logic [c_FILT_W-1:0] r_filt_cnt;
  logic                w_fall;
  logic                w_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s    <= 2'b11;
      r_dat_s    <= 2'b11;
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_s <= {r_clk_s[0], ps2_clk};
      r_dat_s <= {r_dat_s[0], ps2_data};
      if (r_clk_s[1] != r_filt_clk) begin
        if (r_filt_cnt == c_FILT_MAX) begin
          r_filt_clk <= r_clk_s[1];
          r_filt_cnt <= '0;
        end else begin
          r_filt_cnt <= r_filt_cnt + 1'b1;
        end
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  // Sample event is the cycle in which the filtered clock commits to 1->0.
  assign w_fall = r_filt_clk & ~r_clk_s[1] & (r_filt_cnt == c_FILT_MAX);
  assign w_dat  = r_dat_s[1];

  // ---------------------------------------------------------------- deframer
  state_t            r_state, w_state_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic [2:0]        r_bit_cnt, w_bit_cnt_nxt;
  logic [c_TO_W-1:0] r_to_cnt;
  logic              w_timeout;
  logic              w_par_ok;
  logic              w_done;
  logic              w_err;

`ifdef PS2_PARITY_CHK_EN
  logic r_par, w_par_nxt;
  assign w_par_ok = ^{r_shift, r_par};
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_to_cnt == c_TO_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
`ifdef PS2_PARITY_CHK_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
`ifdef PS2_PARITY_CHK_EN
      r_par     <= w_par_nxt;
`endif
      if (r_state == S_IDLE || w_fall)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
`ifdef PS2_PARITY_CHK_EN
    w_par_nxt     = r_par;
`endif
    w_done        = 1'b0;
    w_err         = 1'b0;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_err       = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE: begin
          if (!w_dat) begin
            w_state_nxt   = S_DATA;
            w_bit_cnt_nxt = '0;
          end
        end
        S_DATA: begin
          w_shift_nxt   = {w_dat, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7)
            w_state_nxt = S_PARITY;
        end
        S_PARITY: begin
`ifdef PS2_PARITY_CHK_EN
          w_par_nxt   = w_dat;
`endif
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          w_state_nxt = S_IDLE;
          if (w_dat && w_par_ok)
            w_done = 1'b1;
          else
            w_err = 1'b1;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------ byte handling
  // r_shift cannot change in the cycle after STOP, so it is read directly here.
  logic       r_byte_done;
  logic       r_byte_err;
  logic       r_ext;
  logic       r_brk;
  logic       w_is_e0;
  logic       w_is_f0;
  logic       w_push;
  logic [9:0] w_wdata;

  assign w_is_e0 = (r_shift == 8'hE0);
  assign w_is_f0 = (r_shift == 8'hF0);
  assign w_push  = r_byte_done & ~w_is_e0 & ~w_is_f0;
  assign w_wdata = {r_brk, r_ext, r_shift};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_done <= 1'b0;
      r_byte_err  <= 1'b0;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
    end else begin
      r_byte_done <= w_done;
      r_byte_err  <= w_err;
      if (r_byte_done) begin
        if (w_is_e0) begin
          r_ext <= 1'b1;
        end else if (w_is_f0) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end else if (r_byte_err) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------- event FIFO
  logic [9:0]      r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wptr, r_rptr, w_rptr_nxt;
  logic [c_CW-1:0] r_count, w_count_nxt, w_occ;
  logic            r_valid;
  logic [9:0]      r_head, w_head_nxt;
  logic            r_ovf;
  logic            w_pop, w_full, w_wr, w_ovf;

  assign w_pop       = r_valid & key.key_ready;
  assign w_full      = (r_count == c_FULL);
  assign w_wr        = w_push & (~w_full | w_pop);
  assign w_ovf       = w_push & w_full & ~w_pop;
  assign w_count_nxt = r_count + c_CW'(w_wr) - c_CW'(w_pop);
  assign w_rptr_nxt  = r_rptr + c_AW'(w_pop);
  assign w_occ       = r_count - c_CW'(w_pop);
  // A push into an otherwise-empty FIFO bypasses memory straight into the head.
  assign w_head_nxt  = (w_occ == '0) ? w_wdata : r_mem[w_rptr_nxt];

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wptr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_head  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + 1'b1;
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
      r_head  <= (w_count_nxt != '0) ? w_head_nxt : 10'd0;
      r_ovf   <= w_ovf;
    end
  end

  assign key.key_code  = r_head[7:0];
  assign key.key_ext   = r_head[8];
  assign key.key_brk   = r_head[9];
  assign key.key_valid = r_valid;
  assign ovf           = r_ovf;
  assign frame_err     = r_byte_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_rx.sv
// ============================================================================
// Module  : tb_ps2_key_rx
// Brief   : Directed self-checking bench for ps2_key_rx (bit-banged PS/2 frames).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_key_rx;

  localparam int c_FILT  = 4;
  localparam int c_TO    = 200;
  localparam int c_DEPTH = 4;
  localparam int c_HALF  = 10;

  logic clk;
  logic rst;
  logic ps2_clk;
  logic ps2_data;
  logic ovf;
  logic frame_err;

  ps2_key_rx_if u_key ();

  ps2_key_rx #(
    .FILT_LEN    (c_FILT),
    .TIMEOUT_CYC (c_TO),
    .FIFO_DEPTH  (c_DEPTH)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key       (u_key),
    .ovf       (ovf),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_total = 0;
  int         n_bad   = 0;
  int         n_ovf   = 0;
  int         n_err   = 0;
  logic [9:0] ev_q [$];

  // Record consumed events ({brk,ext,code}) and output pulses away from the edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (u_key.key_valid && u_key.key_ready)
        ev_q.push_back({u_key.key_brk, u_key.key_ext, u_key.key_code});
      if (ovf)
        n_ovf++;
      if (frame_err)
        n_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ev_at(input int i);
    if (i < ev_q.size())
      return ev_q[i];
    return 10'h3FF;
  endfunction

  task automatic clr();
    ev_q.delete();
    n_ovf = 0;
    n_err = 0;
  endtask

  // Sends the first nbits of a frame; glitch >= 0 adds a 1-cycle low pulse after that bit.
  task automatic send_frame(input logic [7:0] b, input logic par_flip,
                            input int nbits, input int glitch);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_data = f[i];
      repeat (c_HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (c_HALF) @(negedge clk);
      ps2_clk = 1'b1;
      if (i == glitch) begin
        repeat (3) @(negedge clk);
        ps2_clk = 1'b0;
        @(negedge clk);
        ps2_clk = 1'b1;
      end
    end
    @(negedge clk) ps2_data = 1'b1;
    repeat (3 * c_HALF) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11, -1);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    ps2_clk         = 1'b1;
    ps2_data        = 1'b1;
    u_key.key_ready = 1'b0;
    rst             = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_valid", u_key.key_valid, 0);
    check("rst_code",  u_key.key_code, 0);
    check("rst_brk",   u_key.key_brk, 0);
    check("rst_ext",   u_key.key_ext, 0);
    check("rst_ovf",   ovf, 0);
    check("rst_ferr",  frame_err, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // single make code
    u_key.key_ready = 1'b1;
    clr();
    send(8'h1C);
    check("t1_n",     ev_q.size(), 1);
    check("t1_ev",    ev_at(0), {2'b00, 8'h1C});
    check("t1_err",   n_err, 0);
    check("t1_valid", u_key.key_valid, 0);

    // break and extended prefixes
    clr();
    send(8'hF0);
    send(8'h1C);
    check("t2_n",  ev_q.size(), 1);
    check("t2_ev", ev_at(0), {2'b10, 8'h1C});
    clr();
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check("t2x_n",  ev_q.size(), 1);
    check("t2x_ev", ev_at(0), {2'b11, 8'h75});

    // overflow: DEPTH+1 frames with consumer stalled
    u_key.key_ready = 1'b0;
    clr();
    for (int k = 0; k <= c_DEPTH; k++)
      send(8'(8'h10 + k));
    check("t3_ovf",   n_ovf, 1);
    check("t3_valid", u_key.key_valid, 1);
    check("t3_head",  u_key.key_code, 8'h10);
    u_key.key_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("t3_n", ev_q.size(), c_DEPTH);
    for (int k = 0; k < c_DEPTH; k++)
      check("t3_ev", ev_at(k), {2'b00, 8'(8'h10 + k)});
    check("t3_empty", u_key.key_valid, 0);

    // wrong parity
    clr();
    send_frame(8'h58, 1'b1, 11, -1);
`ifdef PS2_PARITY_CHK_EN
    check("t4_err", n_err, 1);
    check("t4_n",   ev_q.size(), 0);
`else
    check("t4_err", n_err, 0);
    check("t4_n",   ev_q.size(), 1);
    check("t4_ev",  ev_at(0), {2'b00, 8'h58});
`endif

    // timeout after a partial frame also drops a pending break prefix
    clr();
    send(8'hF0);
    send_frame(8'h1C, 1'b0, 5, -1);
    repeat (c_TO + 50) @(negedge clk);
    check("t5_err", n_err, 1);
    check("t5_n0",  ev_q.size(), 0);
    send(8'h1C);
    check("t5_n",  ev_q.size(), 1);
    check("t5_ev", ev_at(0), {2'b00, 8'h1C});

    // short glitch on ps2_clk mid-frame
    clr();
    send_frame(8'h1C, 1'b0, 11, 5);
    check("t6_n",   ev_q.size(), 1);
    check("t6_ev",  ev_at(0), {2'b00, 8'h1C});
    check("t6_err", n_err, 0);

    // reset mid-frame with the FIFO occupied
    u_key.key_ready = 1'b0;
    clr();
    send(8'h22);
    check("t7_pre", u_key.key_valid, 1);
    send_frame(8'h33, 1'b0, 6, -1);
    rst = 1'b1;
    @(negedge clk);
    check("t7_valid", u_key.key_valid, 0);
    check("t7_code",  u_key.key_code, 0);
    check("t7_ovf",   ovf, 0);
    check("t7_ferr",  frame_err, 0);
    @(negedge clk);
    rst = 1'b0;
    u_key.key_ready = 1'b1;
    clr();
    send(8'h1C);
    repeat (c_TO + 50) @(negedge clk);
    check("t7_n",   ev_q.size(), 1);
    check("t7_ev",  ev_at(0), {2'b00, 8'h1C});
    check("t7_err", n_err, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
